instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/proc_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath width default,
// fetch FSM state encodings and the canonical NOP word.
package proc_pkg;

  localparam int XLEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: first-word-fall-through FIFO with registered storage.
// Ports: push/wdata in, pop/rdata out, flush clears, full/empty/count status.
module fetch_fifo #(
  parameter int depth = 2,
  parameter int width = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [width-1:0]        wdata,
  input  logic                    pop,
  input  logic                    flush,
  output logic [width-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(depth):0]  count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // a push into a full buffer is fine when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // pointers are power-of-two wide, so natural overflow is the modulo wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: takes PCs, issues one memory read at a time, buffers results.
// Ports: pc_in/pc_valid/pc_ready, flush, imem_* bus, instr_out/instr_pc/valid/ready.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_REQ   = REQ;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [XLEN-1:0]   addr_q;
  logic              inflight_q;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              full_or_reserved;
  logic              accept;
  logic              push;
  logic              pop;
  logic [2*XLEN-1:0] head;

  // a slot is claimed when the PC is taken, so a response always fits
  assign full_or_reserved =
    full || ((count + CW'(inflight_q)) == DEPTH_C);

  assign pc_ready = (state_q == S_IDLE)
                  && !full_or_reserved
                  && !flush;
  assign accept   = pc_valid && pc_ready;

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = addr_q;

  assign push = (state_q == S_WAIT) && imem_rvalid && !flush;
  assign pop  = instr_valid && instr_ready;

  assign instr_valid           = !empty;
  assign {instr_pc, instr_out} = head;

  // a flushed request that was already granted still owes one rvalid,
  // which DRAIN swallows; one that returns with the flush is just dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt)   state_d = flush ? S_DRAIN : S_WAIT;
        else if (flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (imem_rvalid) state_d = S_IDLE;
        else if (flush)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= (state_d != S_IDLE);
      if (accept) begin
        addr_q <= pc_in;
      end
    end
  end

  fetch_fifo #(
    .depth (FIFO_DEPTH),
    .width (2 * XLEN)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({addr_q, imem_rdata}),
    .pop     (pop),
    .flush   (flush),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder model, output scoreboard,
// table of single fetches and hand sequences for flush/backpressure/reset.
module tb_instr_fetch;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            pc_ready;
  logic            flush;
  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [XLEN-1:0] imem_rdata = '0;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;

  always #5 clock = ~clock;

  instr_fetch #(
    .FIFO_DEPTH (DEPTH),
    .XLEN       (XLEN)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] pc;
    int          stall;
    int          rdelay;
    logic [31:0] instr;
    int          lat;
  } vec_t;
  vec_t vt[6];

  int gnt_stall = 0;
  int stall_left = 0;
  int rsp_delay = 1;
  int rsp_wait = 0;
  logic [31:0] rsp_addr = '0;

  int lat;
  bit seen;
  int b_acc;
  bit nxt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd5) return 32'hDEAD_BEEF;
    if (a == 32'd7) return 32'h0000_1111;
    return ~a;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: gnt after gnt_stall waiting cycles, rvalid rsp_delay after gnt
  always @(negedge clock) begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(rsp_addr);
      end
    end
    if (imem_req) begin
      if (stall_left > 0) begin
        stall_left--;
      end else begin
        imem_gnt   = 1'b1;
        rsp_wait   = rsp_delay;
        rsp_addr   = imem_addr;
        stall_left = gnt_stall;
      end
    end
  end

  // scoreboard: push on PC acceptance, pop on consumed output
  always @(negedge clock) begin
    #2;
    if (!reset_n || flush) begin
      sb.delete();
    end else begin
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got pc %h instr %h, expected none",
                   instr_pc, instr_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_instr", instr_out, e.instr);
          check("sb_pc", instr_pc, e.pc);
        end
      end
      if (pc_valid && pc_ready) begin
        sb.push_back({pc_in, mem_word(pc_in)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    pc_in = '0;
    pc_valid = 1'b0;
    flush = 1'b0;
    instr_ready = 1'b1;

    vt[0] = '{32'd5,         0, 1, 32'hDEAD_BEEF, 3};
    vt[1] = '{32'h100,       0, 1, 32'hFFFF_FEFF, 3};
    vt[2] = '{32'h1234,      2, 1, 32'hFFFF_EDCB, 5};
    vt[3] = '{32'hFFFF_FFFF, 0, 1, 32'h0000_0000, 3};
    vt[4] = '{32'h0,         1, 2, 32'hFFFF_FFFF, 5};
    vt[5] = '{32'hABC,       4, 1, 32'hFFFF_F543, 7};

    // reset values
    @(negedge clock); #3;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr_out, 0);
    check("rst_ipc", instr_pc, 0);
    check("rst_pc_ready", pc_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;

    // single fetches, latency and request stability under gnt stall
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      gnt_stall  = vt[i].stall;
      stall_left = vt[i].stall;
      rsp_delay  = vt[i].rdelay;
      pc_in      = vt[i].pc;
      pc_valid   = 1'b1;
      #3;
      check("vec_pc_ready", pc_ready, 1);
      lat  = 0;
      seen = 0;
      for (int k = 1; k <= 20 && !seen; k++) begin
        @(negedge clock);
        pc_valid = 1'b0;
        #3;
        if (k <= vt[i].stall + 1) begin
          check("vec_req_held", imem_req, 1);
          check("vec_addr_held", imem_addr, vt[i].pc);
        end
        if (instr_valid) begin
          seen = 1;
          lat  = k;
        end
      end
      check("vec_latency", lat, vt[i].lat);
      check("vec_instr", instr_out, vt[i].instr);
      check("vec_ipc", instr_pc, vt[i].pc);
    end
    gnt_stall  = 0;
    stall_left = 0;
    rsp_delay  = 1;

    // backpressure: PCs 0,1,2 offered, only two fit
    @(negedge clock);
    instr_ready = 1'b0;
    pc_in = 32'd0;
    pc_valid = 1'b1;
    b_acc = 0;
    repeat (14) begin
      #3;
      nxt = pc_valid && pc_ready;
      if (nxt) b_acc++;
      @(negedge clock);
      if (nxt) pc_in = pc_in + 1;
    end
    #3;
    check("bp_accepted", b_acc, 2);
    check("bp_valid", instr_valid, 1);
    check("bp_head_pc", instr_pc, 0);
    check("bp_pc_ready", pc_ready, 0);
    check("bp_req", imem_req, 0);
    @(negedge clock);
    instr_ready = 1'b1;
    #3;
    check("bp_pop_ready", pc_ready, 0);
    @(negedge clock);
    instr_ready = 1'b0;
    #3;
    check("bp_pc2_ready", pc_ready, 1);
    check("bp_pc2_in", pc_in, 2);
    @(negedge clock);
    pc_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (8) @(negedge clock);
    #3;
    check("bp_drained", sb.size(), 0);
    check("bp_idle_valid", instr_valid, 0);

    // simultaneous push and pop with one entry held
    @(negedge clock);
    instr_ready = 1'b0;
    pc_in = 32'h20;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    pc_in = 32'h21;
    pc_valid = 1'b1;
    #3;
    check("pp_valid0", instr_valid, 1);
    check("pp_head0", instr_pc, 32'h20);
    check("pp_ready1", pc_ready, 1);
    @(negedge clock);
    pc_valid = 1'b0;
    @(negedge clock);
    instr_ready = 1'b1;
    #3;
    check("pp_rvalid", imem_rvalid, 1);
    check("pp_head_before", instr_pc, 32'h20);
    @(negedge clock); #3;
    check("pp_count", dut.u_fifo.count, 1);
    check("pp_valid1", instr_valid, 1);
    check("pp_head1", instr_pc, 32'h21);
    @(negedge clock); #3;
    check("pp_empty", instr_valid, 0);

    // flush with an entry buffered, PC offered in the flush cycle
    @(negedge clock);
    instr_ready = 1'b0;
    pc_in = 32'h30;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    @(negedge clock);
    @(negedge clock); #3;
    check("fb_valid", instr_valid, 1);
    @(negedge clock);
    flush = 1'b1;
    pc_in = 32'h31;
    pc_valid = 1'b1;
    #3;
    check("fb_pc_ready", pc_ready, 0);
    @(negedge clock);
    flush = 1'b0;
    pc_valid = 1'b0;
    instr_ready = 1'b1;
    #3;
    check("fb_valid_gone", instr_valid, 0);
    check("fb_no_req", imem_req, 0);

    // flush in REQ before gnt withdraws the request
    @(negedge clock);
    gnt_stall = 3;
    stall_left = 3;
    pc_in = 32'd9;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    flush = 1'b1;
    #3;
    check("fr_req", imem_req, 1);
    @(negedge clock);
    flush = 1'b0;
    #3;
    check("fr_withdrawn", imem_req, 0);
    check("fr_pc_ready", pc_ready, 1);
    gnt_stall = 0;
    stall_left = 0;

    // flush in WAIT, response two cycles after gnt is discarded
    @(negedge clock);
    rsp_delay = 2;
    pc_in = 32'd7;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    @(negedge clock);
    flush = 1'b1;
    #3;
    check("fw_pc_ready_flush", pc_ready, 0);
    @(negedge clock);
    flush = 1'b0;
    #3;
    check("fw_rvalid", imem_rvalid, 1);
    check("fw_drain_ready", pc_ready, 0);
    check("fw_valid_a", instr_valid, 0);
    @(negedge clock); #3;
    check("fw_ready_back", pc_ready, 1);
    check("fw_valid_b", instr_valid, 0);
    @(negedge clock); #3;
    check("fw_valid_c", instr_valid, 0);
    rsp_delay = 1;

    // async reset mid-WAIT with one entry buffered
    @(negedge clock);
    instr_ready = 1'b0;
    pc_in = 32'h50;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rsp_delay = 3;
    pc_in = 32'h51;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    @(negedge clock); #3;
    check("ar_valid_pre", instr_valid, 1);
    reset_n = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("ar_valid", instr_valid, 0);
    check("ar_req", imem_req, 0);
    check("ar_addr", imem_addr, 0);
    check("ar_pc_ready", pc_ready, 1);
    @(negedge clock); #3;
    reset_n = 1'b1;
    rsp_delay = 1;
    repeat (4) begin
      @(negedge clock); #3;
      check("ar_stale", instr_valid, 0);
    end

    repeat (3) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
